video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
// - Raster timing generator and pixel sink for the HDMI/VGA video path. It is the
//   driver side of the pixel_xpos/pixel_ypos -> pixel_data interface used by the
//   video_display pattern/game renderers.
// - Runs free-running H/V counters and requests pixels one cycle ahead, so renderers
//   can register pixel_data. Drives hsync, vsync, DE and RGB toward the TMDS encoder.
// PARAMETERS
// - H_SYNC   40    hsync width, pixels
// - H_BACK   220   horizontal back porch
// - H_DISP   1280  active pixels per line
// - H_FRONT  110   horizontal front porch
// - H_TOTAL  1650  pixels per line; must equal H_SYNC+H_BACK+H_DISP+H_FRONT
// - V_SYNC   5     vsync width, lines
// - V_BACK   20    vertical back porch
// - V_DISP   720   active lines
// - V_FRONT  5     vertical front porch
// - V_TOTAL  750   lines per frame
// - SYNC_POL 1     asserted level of video_hs/video_vs (1 = positive, 720p60)
// PORTS
// - pixel_clk    in   1   pixel clock (74.25 MHz for 720p60)
// - sys_rst      in   1   reset
// - pixel_data   in   24  RGB888 from renderer; valid 1 cycle after data_req
// - data_req     out  1   pixel request; pixel_xpos/ypos valid while high
// - pixel_xpos   out  11  requested column, 0..H_DISP-1; 0 when data_req=0
// - pixel_ypos   out  11  requested row, 0..V_DISP-1; 0 when data_req=0
// - video_hs     out  1   horizontal sync
// - video_vs     out  1   vertical sync
// - video_de     out  1   data enable, active region
// - video_rgb    out  24  RGB888 to encoder
// - frame_start  out  1   1-cycle pulse at h_cnt=0, v_cnt=0
// - frame_cnt    out  8   frames since reset, wraps 255->0
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high.
// - Reset: h_cnt, v_cnt and frame_cnt = 0. While reset is held, data_req=0, video_de=0,
//   video_rgb=0, pixel_xpos/ypos=0 and frame_start=0. video_hs and video_vs sit at
//   SYNC_POL, the decode of count 0. Counting starts on the first edge after release.
// - h_cnt counts 0..H_TOTAL-1 and wraps to 0. When h_cnt=H_TOTAL-1, v_cnt
//   increments, wrapping 0 after V_TOTAL-1. frame_cnt increments on the same
//   edge that wraps v_cnt.
// - HA=H_SYNC+H_BACK, VA=V_SYNC+V_BACK. All outputs decode the current
//   registered counter values; there are no extra pipeline stages.
//   - video_hs = (h_cnt<H_SYNC) ? SYNC_POL : ~SYNC_POL.
//   - video_vs = (v_cnt<V_SYNC) ? SYNC_POL : ~SYNC_POL.
//   - v_act = VA<=v_cnt<VA+V_DISP.
//   - video_de = v_act && HA<=h_cnt<HA+H_DISP.
//   - data_req = v_act && HA-1<=h_cnt<HA+H_DISP-1. It leads video_de by exactly 1 cycle
//     and never crosses a line boundary.
//   - pixel_xpos = h_cnt-(HA-1) and pixel_ypos = v_cnt-VA while data_req=1;
//     otherwise both are 0. Subtraction is 11-bit and never negative inside the window.
// - video_rgb = video_de ? pixel_data : 24'd0. Blanking is always black, whatever
//   the renderer drives.
// - Latency contract: the renderer registers pixel_data one cycle after the
//   xpos/ypos it sees. That value is on video_rgb in the cycle video_de is high for that pixel.
// - Reset mid-frame aborts the frame immediately; no partial-line completion.
// STRUCTURE
// - Shared include video_timing_defs.vh holds the 720p60 constants (H_*/V_*), the colour
//   constants (BLACK/WHITE/BLUE), and H_DISP/V_DISP, which video_display also uses.
// - One sub-module, sync_axis_cnt (parameters SYNC, BACK, DISP, TOTAL; ports inc_en,
//   cnt, wrap, sync, active, pre_active), is instantiated twice:
//   - H axis: inc_en=1.
//   - V axis: inc_en = H wrap.
// - The top level combines the two axes, applies the data_req lead, and does the RGB gating.
// TESTING
// - Release reset: h_cnt counts to 1649 then 0, v_cnt=1. video_hs=1 for h_cnt 0..39,
//   0 for h_cnt 40..1649.
// - Frame 0 at v_cnt=25, h_cnt=259: data_req=1 with xpos=0, ypos=0. Next cycle: video_de=1,
//   and video_rgb equals the pixel_data driven for (0,0).
// - Line 25 end: last data_req at h_cnt=1538 with xpos=1279; last video_de at h_cnt=1539.
//   At h_cnt=1540: de=0, rgb=0.
// - Frame wrap: v_cnt=749, h_cnt=1649 -> both 0 next cycle; frame_start pulses 1 cycle.
//   frame_cnt preset 255 -> 0. video_vs=1 for v_cnt 0..4.
// - Blanking: hold pixel_data=24'hFFFFFF at v_cnt=10 -> video_rgb=0, data_req=0 all line.
// - Mid-frame reset: assert sys_rst at v_cnt=400, h_cnt=700 -> same cycle de=0, rgb=0,
//   data_req=0. After release, v_cnt and h_cnt restart at 0.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared 720p60 raster constants, colour constants and small helpers for the
// video timing path.
package video_timing_gen_pkg;

  localparam int CNT_W  = 11;
  localparam int RGB_W  = 24;
  localparam int FCNT_W = 8;

  localparam int H_SYNC_720P  = 40;
  localparam int H_BACK_720P  = 220;
  localparam int H_DISP_720P  = 1280;
  localparam int H_FRONT_720P = 110;
  localparam int H_TOTAL_720P = 1650;

  localparam int V_SYNC_720P  = 5;
  localparam int V_BACK_720P  = 20;
  localparam int V_DISP_720P  = 720;
  localparam int V_FRONT_720P = 5;
  localparam int V_TOTAL_720P = 750;

  localparam logic [RGB_W-1:0] BLACK = 24'h000000;
  localparam logic [RGB_W-1:0] WHITE = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BLUE  = 24'h0000FF;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [FCNT_W-1:0] fcnt_t;

  function automatic logic sync_level(input logic in_sync, input logic pol);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_axis_cnt.sv
// One raster axis: wrapping position counter plus sync/active/pre-active
// window decodes. Instantiated once per axis by video_timing_gen.
module sync_axis_cnt
  import video_timing_gen_pkg::*;
#(
  parameter int SYNC  = 40,
  parameter int BACK  = 220,
  parameter int DISP  = 1280,
  parameter int TOTAL = 1650
) (
  input  logic pixel_clk,
  input  logic sys_rst,
  input  logic inc_en,
  output cnt_t cnt,
  output logic wrap,
  output logic sync,
  output logic active,
  output logic pre_active
);

  localparam cnt_t LAST     = CNT_W'(TOTAL - 1);
  localparam cnt_t SYNC_END = CNT_W'(SYNC);
  localparam cnt_t ACT_LO   = CNT_W'(SYNC + BACK);
  localparam cnt_t ACT_HI   = CNT_W'(SYNC + BACK + DISP);
  localparam cnt_t PRE_LO   = CNT_W'(SYNC + BACK - 1);
  localparam cnt_t PRE_HI   = CNT_W'(SYNC + BACK + DISP - 1);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt        = cnt_q;
  assign wrap       = inc_en && (cnt_q == LAST);
  assign sync       = (cnt_q < SYNC_END);
  assign active     = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);
  assign pre_active = (cnt_q >= PRE_LO) && (cnt_q < PRE_HI);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel sink: requests pixels one cycle ahead of
// DE, gates RGB to black outside the active region, and counts frames.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BACK   = H_BACK_720P,
  parameter int   H_DISP   = H_DISP_720P,
  parameter int   H_FRONT  = H_FRONT_720P,
  parameter int   H_TOTAL  = H_TOTAL_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BACK   = V_BACK_720P,
  parameter int   V_DISP   = V_DISP_720P,
  parameter int   V_FRONT  = V_FRONT_720P,
  parameter int   V_TOTAL  = V_TOTAL_720P,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic [RGB_W-1:0]  pixel_data,
  output logic              data_req,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic              video_hs,
  output logic              video_vs,
  output logic              video_de,
  output logic [RGB_W-1:0]  video_rgb,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  // A line/frame length that disagrees with its segments falls back to the
  // segment sum so the porches are never silently truncated.
  localparam int H_SUM = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_SUM = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_LEN = (H_TOTAL == H_SUM) ? H_TOTAL : H_SUM;
  localparam int V_LEN = (V_TOTAL == V_SUM) ? V_TOTAL : V_SUM;

  localparam cnt_t X_OFF = CNT_W'(H_SYNC + H_BACK - 1);
  localparam cnt_t Y_OFF = CNT_W'(V_SYNC + V_BACK);

  cnt_t  h_cnt, v_cnt;
  logic  h_wrap, h_sync, h_act, h_pre;
  logic  v_wrap, v_sync, v_act, v_pre_unused;
  logic  run;
  fcnt_t frame_cnt_q, frame_cnt_d;

  sync_axis_cnt #(
    .SYNC (H_SYNC),
    .BACK (H_BACK),
    .DISP (H_DISP),
    .TOTAL(H_LEN)
  ) u_h_axis (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .inc_en    (1'b1),
    .cnt       (h_cnt),
    .wrap      (h_wrap),
    .sync      (h_sync),
    .active    (h_act),
    .pre_active(h_pre)
  );

  sync_axis_cnt #(
    .SYNC (V_SYNC),
    .BACK (V_BACK),
    .DISP (V_DISP),
    .TOTAL(V_LEN)
  ) u_v_axis (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .inc_en    (h_wrap),
    .cnt       (v_cnt),
    .wrap      (v_wrap),
    .sync      (v_sync),
    .active    (v_act),
    .pre_active(v_pre_unused)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Strobes are gated by reset directly so a mid-frame reset blanks the
  // output in the same cycle, not one edge later.
  assign run         = ~sys_rst;
  assign video_hs    = sync_level(h_sync, SYNC_POL);
  assign video_vs    = sync_level(v_sync, SYNC_POL);
  assign video_de    = run && v_act && h_act;
  assign data_req    = run && v_act && h_pre;
  assign pixel_xpos  = data_req ? cnt_t'(h_cnt - X_OFF) : '0;
  assign pixel_ypos  = data_req ? cnt_t'(v_cnt - Y_OFF) : '0;
  assign video_rgb   = video_de ? pixel_data : BLACK;
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a full 720p instance for line/boundary timing and a tiny
// raster instance for frame wrap and the frame counter roll-over.
module tb_video_timing_gen;

  localparam int HT  = 1650;
  localparam int SHT = 11;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        rst_s;
  logic        force_en;
  logic [23:0] rend_q;
  logic [23:0] pixel_data;
  logic        data_req, video_hs, video_vs, video_de, frame_start;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic [23:0] video_rgb;
  logic [7:0]  frame_cnt;

  logic        data_req_s, video_hs_s, video_vs_s, video_de_s, frame_start_s;
  logic [10:0] pixel_xpos_s, pixel_ypos_s;
  logic [23:0] video_rgb_s;
  logic [7:0]  frame_cnt_s;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cyc_s    = 0;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .pixel_clk  (clk),
    .sys_rst    (sys_rst),
    .pixel_data (pixel_data),
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .video_hs   (video_hs),
    .video_vs   (video_vs),
    .video_de   (video_de),
    .video_rgb  (video_rgb),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  // Tiny raster: 2/3/4/2 = 11 pixels, 1/2/3/1 = 7 lines, 77 cycles per frame.
  video_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(4), .H_FRONT(2), .H_TOTAL(11),
    .V_SYNC(1), .V_BACK(2), .V_DISP(3), .V_FRONT(1), .V_TOTAL(7),
    .SYNC_POL(1'b1)
  ) dut_s (
    .pixel_clk  (clk),
    .sys_rst    (rst_s),
    .pixel_data (24'h123456),
    .data_req   (data_req_s),
    .pixel_xpos (pixel_xpos_s),
    .pixel_ypos (pixel_ypos_s),
    .video_hs   (video_hs_s),
    .video_vs   (video_vs_s),
    .video_de   (video_de_s),
    .video_rgb  (video_rgb_s),
    .frame_start(frame_start_s),
    .frame_cnt  (frame_cnt_s)
  );

  function automatic logic [23:0] pat(input logic [10:0] x, input logic [10:0] y);
    return {y[7:0] ^ 8'hC3, 5'b10101, x};
  endfunction

  // Renderer model: registers a colour for the coordinate it was asked for.
  always @(posedge clk) rend_q <= pat(pixel_xpos, pixel_ypos);
  assign pixel_data = force_en ? 24'hFFFFFF : rend_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc   += n;
    cyc_s += n;
  endtask

  task automatic go(input int v, input int h);
    if (v * HT + h > cyc) step(v * HT + h - cyc);
  endtask

  task automatic go_s(input int c);
    if (c > cyc_s) step(c - cyc_s);
  endtask

  initial begin
    int bad;
    sys_rst  = 1'b1;
    rst_s    = 1'b1;
    force_en = 1'b0;
    step(3);

    check("rst_de",    video_de, 0);
    check("rst_req",   data_req, 0);
    check("rst_rgb",   video_rgb, 0);
    check("rst_xpos",  pixel_xpos, 0);
    check("rst_fs",    frame_start, 0);
    check("rst_hs",    video_hs, 1);
    check("rst_vs",    video_vs, 1);
    check("rst_fcnt",  frame_cnt, 0);
    check("rst_s_fs",  frame_start_s, 0);

    sys_rst = 1'b0;
    #1;
    cyc = 0;
    check("rel_fs",    frame_start, 1);
    step(1);
    check("fs_pulse",  frame_start, 0);
    go(0, 39);   check("hs_h39",   video_hs, 1);
    go(0, 40);   check("hs_h40",   video_hs, 0);
    go(0, 1649); check("hs_h1649", video_hs, 0);
    go(1, 0);    check("hs_l1_h0", video_hs, 1);
                 check("vs_l1",    video_vs, 1);
                 check("fs_l1",    frame_start, 0);
    go(4, 1649); check("vs_l4",    video_vs, 1);
    go(5, 0);    check("vs_l5",    video_vs, 0);

    go(10, 0);
    force_en = 1'b1;
    bad = 0;
    for (int i = 0; i < HT; i++) begin
      if (i == 260) check("blank_de", video_de, 0);
      if (video_rgb !== 24'd0 || data_req !== 1'b0) bad++;
      step(1);
    end
    check("blank_line", bad, 0);
    force_en = 1'b0;

    go(24, 259);  check("l24_req",   data_req, 0);
    go(25, 258);  check("l25_req0",  data_req, 0);
    go(25, 259);  check("first_req", data_req, 1);
                  check("first_x",   pixel_xpos, 0);
                  check("first_y",   pixel_ypos, 0);
                  check("first_de0", video_de, 0);
    go(25, 260);  check("first_de",  video_de, 1);
                  check("first_rgb", video_rgb, pat(11'd0, 11'd0));
    go(25, 800);  check("mid_x",     pixel_xpos, 541);
                  check("mid_rgb",   video_rgb, pat(11'd540, 11'd0));
    go(25, 1538); check("last_req",  data_req, 1);
                  check("last_x",    pixel_xpos, 1279);
    go(25, 1539); check("end_req",   data_req, 0);
                  check("end_x",     pixel_xpos, 0);
                  check("last_de",   video_de, 1);
                  check("last_rgb",  video_rgb, pat(11'd1279, 11'd0));
    go(25, 1540); check("post_de",   video_de, 0);
                  check("post_rgb",  video_rgb, 0);
    go(26, 259);  check("l26_y",     pixel_ypos, 1);
    go(26, 700);  check("l26_de",    video_de, 1);
                  check("l26_rgb",   video_rgb, pat(11'd440, 11'd1));

    sys_rst = 1'b1;
    #1;
    check("mrst_de",  video_de, 0);
    check("mrst_rgb", video_rgb, 0);
    check("mrst_req", data_req, 0);
    check("mrst_hs",  video_hs, 1);
    check("mrst_vs",  video_vs, 1);
    step(2);
    sys_rst = 1'b0;
    #1;
    cyc = 0;
    check("mrel_fs",  frame_start, 1);
    go(0, 39);    check("mrel_h39", video_hs, 1);
    go(0, 40);    check("mrel_h40", video_hs, 0);

    rst_s = 1'b0;
    #1;
    cyc_s = 0;
    check("s_fs0",    frame_start_s, 1);
    check("s_fcnt0",  frame_cnt_s, 0);
    go_s(3 * SHT + 4); check("s_req",   data_req_s, 1);
                       check("s_x0",    pixel_xpos_s, 0);
                       check("s_y0",    pixel_ypos_s, 0);
    go_s(3 * SHT + 5); check("s_de",    video_de_s, 1);
                       check("s_rgb",   video_rgb_s, 24'h123456);
    go_s(5 * SHT + 7); check("s_x3",    pixel_xpos_s, 3);
                       check("s_y2",    pixel_ypos_s, 2);
    go_s(5 * SHT + 8); check("s_req_e", data_req_s, 0);
                       check("s_de_e",  video_de_s, 1);
    go_s(6 * SHT + 4); check("s_l6req", data_req_s, 0);
    go_s(76);          check("s_fs76",  frame_start_s, 0);
                       check("s_vs76",  video_vs_s, 0);
    go_s(77);          check("s_fs77",  frame_start_s, 1);
                       check("s_fc1",   frame_cnt_s, 1);
                       check("s_vs77",  video_vs_s, 1);
    go_s(256 * 77 - 1); check("s_fc255", frame_cnt_s, 255);
                        check("s_fs_pre", frame_start_s, 0);
    go_s(256 * 77);     check("s_fcwrap", frame_cnt_s, 0);
                        check("s_fswrap", frame_start_s, 1);
    go_s(256 * 77 + 1); check("s_fsdrop", frame_start_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
